// File: rtl/axis_frame_builder.sv
// AXI-Stream framer: emits a header beat (first beat's tuser) followed by
// FRAME_LEN payload beats, with tlast on the final payload beat.
module axis_frame_builder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 8,
  parameter int unsigned FRAME_LEN  = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [USER_WIDTH-1:0] s_tuser,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready
);

  localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  if (USER_WIDTH > DATA_WIDTH) begin : g_user_width_check
    $error("axis_frame_builder: USER_WIDTH must not exceed DATA_WIDTH");
  end
  if (FRAME_LEN < 1) begin : g_frame_len_check
    $error("axis_frame_builder: FRAME_LEN must be at least 1");
  end

  typedef enum logic [0:0] {
    HEADER  = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] m_tdata_d;
  logic                  m_tlast_d;
  logic                  m_tvalid_d;
  logic                  load;
  logic                  is_last;

  // State and output register stage.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= HEADER;
      cnt_q    <= '0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tvalid <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m_tdata  <= m_tdata_d;
      m_tlast  <= m_tlast_d;
      m_tvalid <= m_tvalid_d;
    end
  end

  // Next-state and output-load logic; s_tready never depends on s_tvalid.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    m_tdata_d  = m_tdata;
    m_tlast_d  = m_tlast;
    m_tvalid_d = m_tvalid;
    s_tready   = 1'b0;
    load       = !m_tvalid || m_tready;
    is_last    = (cnt_q == LAST_IDX);

    unique case (state_q)
      HEADER: begin
        // Header is built from the pending beat, which is not consumed here.
        if (load) begin
          if (s_tvalid) begin
            m_tdata_d  = DATA_WIDTH'(s_tuser);
            m_tlast_d  = 1'b0;
            m_tvalid_d = 1'b1;
            cnt_d      = '0;
            state_d    = PAYLOAD;
          end else begin
            m_tvalid_d = 1'b0;
          end
        end
      end
      PAYLOAD: begin
        s_tready = load;
        if (load) begin
          if (s_tvalid) begin
            m_tdata_d  = s_tdata;
            m_tlast_d  = is_last;
            m_tvalid_d = 1'b1;
            if (is_last) begin
              cnt_d   = '0;
              state_d = HEADER;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            m_tvalid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = HEADER;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_frame_builder.sv
// Randomized and directed bench for axis_frame_builder, scored against a
// frame-level model of the expected output stream.
module tb_axis_frame_builder;

  localparam int unsigned FL = 4;

  logic        clock = 1'b0;
  logic        resetn;

  logic [7:0]  s_tdata, s_tuser, m_tdata;
  logic        s_tvalid, s_tready, m_tlast, m_tvalid, m_tready;

  logic [15:0] b_s_tdata, b_m_tdata;
  logic [7:0]  b_s_tuser;
  logic        b_s_tvalid, b_s_tready, b_m_tlast, b_m_tvalid, b_m_tready;

  int checks = 0;
  int errors = 0;

  logic [7:0] bd [0:63];
  logic [7:0] bu [0:63];
  logic [8:0] exp_q [$];

  always #5 clock = ~clock;

  axis_frame_builder #(.DATA_WIDTH(8), .USER_WIDTH(8), .FRAME_LEN(FL)) dut (
    .clock(clock), .resetn(resetn),
    .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready)
  );

  axis_frame_builder #(.DATA_WIDTH(16), .USER_WIDTH(8), .FRAME_LEN(1)) dut_b (
    .clock(clock), .resetn(resetn),
    .s_tdata(b_s_tdata), .s_tuser(b_s_tuser), .s_tvalid(b_s_tvalid), .s_tready(b_s_tready),
    .m_tdata(b_m_tdata), .m_tlast(b_m_tlast), .m_tvalid(b_m_tvalid), .m_tready(b_m_tready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit offer(input int cyc, input int vmode);
    case (vmode)
      0:       return 1'b1;
      1:       return (cyc % 3) == 0;
      default: return 1'($urandom_range(1, 0));
    endcase
  endfunction

  function automatic logic ready_pick(input int cyc, input int rmode);
    case (rmode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      default: return 1'($urandom_range(1, 0));
    endcase
  endfunction

  // Runs n beats through the main DUT; stop_after>0 aborts after that many outputs.
  task automatic run(input int n, input int vmode, input int rmode,
                     input bit directed, input int stop_after);
    int in_idx = 0;
    int out_idx = 0;
    int cyc = 0;
    int target;
    int drops = 0;
    bit accepted, prev_stall, seen_v;
    logic [7:0] prev_d;
    logic prev_l;
    prev_stall = 1'b0;
    seen_v = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      bd[i] = directed ? 8'(8'h10 + i) : 8'($urandom);
      bu[i] = directed ? 8'(i) : 8'($urandom);
      if (i % FL == 0) exp_q.push_back({1'b0, bu[i]});
      exp_q.push_back({1'(i % FL == FL - 1), bd[i]});
    end
    target = (stop_after > 0) ? stop_after : exp_q.size();
    s_tvalid = 1'b0;
    if (offer(0, vmode)) begin
      s_tvalid = 1'b1;
      s_tdata  = bd[0];
      s_tuser  = bu[0];
    end
    m_tready = ready_pick(0, rmode);
    while (out_idx < target && cyc < 2000) begin
      @(negedge clock);
      if (m_tvalid && !m_tready) check("sready_in_stall", 32'(s_tready), 32'd0);
      if (prev_stall) begin
        check("stall_valid", 32'(m_tvalid), 32'd1);
        check("stall_data", 32'(m_tdata), 32'(prev_d));
        check("stall_last", 32'(m_tlast), 32'(prev_l));
      end
      if (vmode == 0 && rmode == 0) begin
        if (cyc == 0) check("latency_c0", 32'(m_tvalid), 32'd0);
        if (cyc >= 1 && out_idx < exp_q.size()) check("tvalid_cont", 32'(m_tvalid), 32'd1);
      end
      if (seen_v && !m_tvalid) drops++;
      if (m_tvalid) seen_v = 1'b1;
      if (m_tvalid && m_tready) begin
        check($sformatf("out_data[%0d]", out_idx), 32'(m_tdata), 32'(exp_q[out_idx][7:0]));
        check($sformatf("out_last[%0d]", out_idx), 32'(m_tlast), 32'(exp_q[out_idx][8]));
        out_idx++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d     = m_tdata;
      prev_l     = m_tlast;
      accepted   = s_tvalid && s_tready;
      @(posedge clock);
      #1;
      cyc++;
      if (accepted) begin
        in_idx++;
        s_tvalid = 1'b0;
      end
      if (!s_tvalid && in_idx < n && offer(cyc, vmode)) begin
        s_tvalid = 1'b1;
        s_tdata  = bd[in_idx];
        s_tuser  = bu[in_idx];
      end
      m_tready = ready_pick(cyc, rmode);
    end
    check("run_outputs", 32'(out_idx), 32'(target));
    if (stop_after == 0) check("beats_in", 32'(in_idx), 32'(n));
    if (vmode == 1) check("tvalid_drops", 32'(drops > 0), 32'd1);
    s_tvalid = 1'b0;
  endtask

  initial begin
    logic [16:0] got [$];
    logic [15:0] bdat [0:1];
    logic [7:0]  buse [0:1];
    logic [16:0] bexp [0:3];
    bit acc;

    resetn = 1'b0;
    s_tdata = '0; s_tuser = '0; s_tvalid = 1'b0; m_tready = 1'b0;
    b_s_tdata = '0; b_s_tuser = '0; b_s_tvalid = 1'b0; b_m_tready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_sready", 32'(s_tready), 32'd0);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    run(8, 0, 0, 1'b1, 0);
    run(8, 0, 1, 1'b1, 0);
    run(8, 1, 0, 1'b1, 0);
    run(16, 2, 2, 1'b0, 0);
    run(12, 1, 2, 1'b0, 0);
    run(20, 2, 1, 1'b0, 0);

    // Mid-frame reset after header plus two payload beats.
    run(8, 0, 0, 1'b1, 3);
    #2;
    resetn = 1'b0;
    #1;
    check("amid_rst_tvalid", 32'(m_tvalid), 32'd0);
    check("amid_rst_tdata", 32'(m_tdata), 32'd0);
    check("amid_rst_tlast", 32'(m_tlast), 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    check("post_rst_sready", 32'(s_tready), 32'd0);
    check("post_rst_tvalid", 32'(m_tvalid), 32'd0);
    @(posedge clock);
    #1;
    run(8, 2, 0, 1'b0, 0);

    // Wide-data, single-beat-frame instance.
    bdat[0] = 16'h003C; buse[0] = 8'hA5;
    bdat[1] = 16'h0055; buse[1] = 8'hFF;
    bexp[0] = {1'b0, 16'h00A5};
    bexp[1] = {1'b1, 16'h003C};
    bexp[2] = {1'b0, 16'h00FF};
    bexp[3] = {1'b1, 16'h0055};
    b_m_tready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      b_s_tvalid = 1'b1;
      b_s_tdata  = bdat[k];
      b_s_tuser  = buse[k];
      for (int c = 0; c < 10; c++) begin
        @(negedge clock);
        if (b_m_tvalid && b_m_tready) got.push_back({b_m_tlast, b_m_tdata});
        acc = b_s_tvalid && b_s_tready;
        @(posedge clock);
        #1;
        if (acc) break;
      end
      b_s_tvalid = 1'b0;
    end
    repeat (4) begin
      @(negedge clock);
      if (b_m_tvalid && b_m_tready) got.push_back({b_m_tlast, b_m_tdata});
    end
    check("b_count", 32'(got.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < got.size()) check($sformatf("b_beat[%0d]", k), 32'(got[k]), 32'(bexp[k]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
